mips_perf_counters: RTL and testbench

Parametrised performance-counter and readout unit for the MIPS CPU top level. It counts cycles plus `NUM_CH` independent event channels, such as retired instructions, loads, stores and branches. On request it freezes all counts into a shadow bank and streams them out byte-wise on the 8-bit `mips_cpu_perf_sig` bus under a valid/ready handshake. It generalises the fixed 8-bit perf signal to any channel count and counter width, adds wrap/saturate modes, and adds sticky overflow reporting.

---
 rtl/mips_perf_counters_if.sv | 25 ++
 rtl/mips_perf_counters.sv | 145 ++++++++++++++
 tb/tb_mips_perf_counters.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_perf_counters_if.sv
// Byte-stream readout bus of the performance-counter unit: data, valid/ready
// handshake and the snapshot status strobes.
interface mips_perf_counters_if;
  logic [7:0] mips_cpu_perf_sig;
  logic       perf_valid;
  logic       perf_ready;
  logic       snap_busy;
  logic       snap_done;

  modport master (
    output mips_cpu_perf_sig,
    output perf_valid,
    output snap_busy,
    output snap_done,
    input  perf_ready
  );

  modport slave (
    input  mips_cpu_perf_sig,
    input  perf_valid,
    input  snap_busy,
    input  snap_done,
    output perf_ready
  );
endinterface

// File: rtl/mips_perf_counters.sv
// Cycle counter plus NUM_CH event counters with sticky overflow; a snapshot
// freezes them into a shadow bank that is streamed out byte-wise, LSB first.
module mips_perf_counters #(
  parameter int         NUM_CH   = 4,
  parameter int         CNT_W    = 32,
  parameter int         SAT_MODE = 0,
  parameter logic [7:0] HDR      = 8'hA5
) (
  input  logic              mips_cpu_clk,
  input  logic              mips_cpu_reset,
  input  logic              cnt_en,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              clear,
  input  logic              snap_req,
  mips_perf_counters_if.master perf
);

  localparam int NCNT   = NUM_CH + 1;
  localparam int BPC    = CNT_W / 8;
  localparam int CB     = NCNT * BPC;
  localparam int NBYTES = CB + 2;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q [NCNT];
  logic [CNT_W-1:0]    cnt_d [NCNT];
  logic [NCNT-1:0]     ovf_q, ovf_d;
  logic [CB*8-1:0]     shCnt_q, shCnt_d;
  logic [NCNT-1:0]     shOvf_q, shOvf_d;
  logic [NCNT-1:0]     due;
  logic [CB*8-1:0]     liveFlat;
  logic [7:0]          trailer;
  logic [7:0]          byteSel;

  // Channel 0 is the cycle counter, so it only needs the global enable.
  assign due = {event_i, 1'b1} & {NCNT{cnt_en}};

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear) begin
        cnt_d[i] = {CNT_W{1'b0}};
        ovf_d[i] = 1'b0;
      end else if (due[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT_MODE != 0) ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      liveFlat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  // Shadow bank captures the values seen this cycle, before clear/increment.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    shCnt_d = shCnt_q;
    shOvf_d = shOvf_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          shCnt_d = liveFlat;
          shOvf_d = ovf_q;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (perf.perf_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      shCnt_q <= '0;
      shOvf_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      shCnt_q <= shCnt_d;
      shOvf_q <= shOvf_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign trailer = 8'(shOvf_q);

  // Byte 0 is the header, the last byte the overflow trailer, the rest counters.
  always_comb begin
    byteSel = 8'h00;
    if (idx_q == '0) begin
      byteSel = HDR;
    end else if (idx_q == LAST_IDX) begin
      byteSel = trailer;
    end else begin
      for (int j = 0; j < CB; j++) begin
        if (idx_q == IDX_W'(j + 1)) begin
          byteSel = shCnt_q[j*8 +: 8];
        end
      end
    end
  end

  assign perf.perf_valid        = (state_q == STREAM);
  assign perf.snap_busy         = (state_q == STREAM);
  assign perf.snap_done         = done_q;
  assign perf.mips_cpu_perf_sig = (state_q == STREAM) ? byteSel : 8'h00;

endmodule

// File: tb/tb_mips_perf_counters.sv
// Directed bench: a default 32-bit instance plus 8-bit wrap and saturate
// instances share stimulus; every stream is compared with hand-computed bytes.
module tb_mips_perf_counters;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cntEn;
  logic [3:0] eventVec;
  logic       clr;
  logic       snapReq;
  logic       ready;

  int passCount = 0;
  int checkCount = 0;

  mips_perf_counters_if ifD ();
  mips_perf_counters_if ifW ();
  mips_perf_counters_if ifS ();

  assign ifD.perf_ready = ready;
  assign ifW.perf_ready = ready;
  assign ifS.perf_ready = ready;

  mips_perf_counters #(.NUM_CH(4), .CNT_W(32), .SAT_MODE(0), .HDR(8'hA5)) uD (
    .mips_cpu_clk(clk), .mips_cpu_reset(rstN), .cnt_en(cntEn), .event_i(eventVec),
    .clear(clr), .snap_req(snapReq), .perf(ifD));

  mips_perf_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(0), .HDR(8'hA5)) uW (
    .mips_cpu_clk(clk), .mips_cpu_reset(rstN), .cnt_en(cntEn), .event_i(eventVec),
    .clear(clr), .snap_req(snapReq), .perf(ifW));

  mips_perf_counters #(.NUM_CH(4), .CNT_W(8), .SAT_MODE(1), .HDR(8'hA5)) uS (
    .mips_cpu_clk(clk), .mips_cpu_reset(rstN), .cnt_en(cntEn), .event_i(eventVec),
    .clear(clr), .snap_req(snapReq), .perf(ifS));

  always #5 clk = ~clk;

  logic       vld [3];
  logic [7:0] sig [3];
  logic       dn  [3];
  logic       bsy [3];

  assign vld[0] = ifD.perf_valid;  assign sig[0] = ifD.mips_cpu_perf_sig;
  assign vld[1] = ifW.perf_valid;  assign sig[1] = ifW.mips_cpu_perf_sig;
  assign vld[2] = ifS.perf_valid;  assign sig[2] = ifS.mips_cpu_perf_sig;
  assign dn[0]  = ifD.snap_done;   assign bsy[0] = ifD.snap_busy;
  assign dn[1]  = ifW.snap_done;   assign bsy[1] = ifW.snap_busy;
  assign dn[2]  = ifS.snap_done;   assign bsy[2] = ifS.snap_busy;

  logic [7:0] got [3][64];
  int nGot [3];
  int doneCnt [3];
  int firstDone [3];
  int holdErr, gapErr, zeroErr;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Counting burst starting and ending on a falling edge; events on the first evCount cycles.
  task automatic applyStimulus(input int cycles, input logic [3:0] pattern, input int evCount);
    for (int c = 0; c < cycles; c++) begin
      cntEn    = 1'b1;
      eventVec = (c < evCount) ? pattern : 4'b0000;
      @(negedge clk);
    end
    cntEn    = 1'b0;
    eventVec = 4'b0000;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
  endtask

  // Requests a snapshot and watches all three streams for a fixed 80-cycle window.
  task automatic runSnap(input bit withClear, input bit toggleReady,
                         input bit extraReq, input int abortAfter);
    logic       prevValid, prevReady;
    logic [7:0] prevSig;
    int         abortCyc;
    for (int k = 0; k < 3; k++) begin
      nGot[k] = 0; doneCnt[k] = 0; firstDone[k] = 0;
    end
    holdErr = 0; gapErr = 0; zeroErr = 0; abortCyc = 0;
    prevValid = 1'b0; prevReady = 1'b1; prevSig = 8'h00;
    ready   = 1'b1;
    snapReq = 1'b1;
    clr     = withClear;
    @(negedge clk);
    snapReq = 1'b0;
    clr     = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      ready   = toggleReady ? cyc[0] : 1'b1;
      snapReq = extraReq && (cyc == 5);
      if (abortCyc > 0 && cyc == abortCyc + 1) rstN = 1'b0;
      if (abortCyc > 0 && cyc == abortCyc + 2) begin
        checkOutput("abort_valid", vld[0], 0);
        checkOutput("abort_busy", bsy[0], 0);
        checkOutput("abort_done", dn[0], 0);
        rstN = 1'b1;
      end
      if (prevValid && !prevReady && (!vld[0] || sig[0] != prevSig)) holdErr++;
      if (!vld[0] && nGot[0] > 0 && nGot[0] < 22 && abortCyc == 0) gapErr++;
      for (int k = 0; k < 3; k++) begin
        if (!vld[k] && sig[k] != 8'h00) zeroErr++;
        if (dn[k]) begin
          doneCnt[k]++;
          if (firstDone[k] == 0) firstDone[k] = cyc;
        end
        if (vld[k] && ready && rstN && nGot[k] < 64) begin
          got[k][nGot[k]] = sig[k];
          nGot[k]++;
        end
      end
      if (abortAfter > 0 && abortCyc == 0 && nGot[0] == abortAfter) abortCyc = cyc;
      prevValid = vld[0]; prevReady = ready; prevSig = sig[0];
      @(negedge clk);
    end
    snapReq = 1'b0;
    ready   = 1'b1;
  endtask

  task automatic checkStream(input int k, input string tag,
                             input logic [63:0] c0, input logic [63:0] c1,
                             input logic [63:0] c2, input logic [63:0] c3,
                             input logic [63:0] c4, input logic [7:0] trl);
    logic [63:0] c [5];
    logic [63:0] v;
    logic [7:0]  e;
    int bpc, n;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
    bpc = (k == 0) ? 4 : 1;
    n   = 2 + 5 * bpc;
    checkOutput({tag, "_count"}, 64'(nGot[k]), 64'(n));
    for (int j = 0; j < n; j++) begin
      if (j == 0) e = 8'hA5;
      else if (j == n - 1) e = trl;
      else begin
        v = c[(j-1)/bpc] >> (8 * ((j-1) % bpc));
        e = v[7:0];
      end
      checkOutput($sformatf("%s_byte%0d", tag, j), got[k][j], e);
    end
  endtask

  initial begin
    rstN = 1'b0; cntEn = 1'b0; eventVec = 4'b0000; clr = 1'b0; snapReq = 1'b0; ready = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    doReset();
    checkOutput("rst_valid", vld[0], 0);
    checkOutput("rst_busy", bsy[0], 0);
    checkOutput("rst_done", dn[0], 0);
    checkOutput("rst_sig", sig[0], 0);
    runSnap(0, 0, 0, 0);
    checkStream(0, "rst_D", 0, 0, 0, 0, 0, 8'h00);
    checkStream(1, "rst_W", 0, 0, 0, 0, 0, 8'h00);
    checkOutput("rst_doneCycle_D", 64'(firstDone[0]), 23);
    checkOutput("rst_doneCycle_W", 64'(firstDone[1]), 8);
    checkOutput("rst_zeroWhenIdle", 64'(zeroErr), 0);

    $display("[TB] counting");
    doReset();
    applyStimulus(10, 4'b0101, 3);
    runSnap(0, 0, 0, 0);
    checkStream(0, "cnt_D", 10, 3, 0, 3, 0, 8'h00);
    checkStream(2, "cnt_S", 10, 3, 0, 3, 0, 8'h00);
    checkOutput("cnt_doneCnt", 64'(doneCnt[0]), 1);

    $display("[TB] backpressure");
    runSnap(0, 1, 0, 0);
    checkStream(0, "bp_D", 10, 3, 0, 3, 0, 8'h00);
    checkOutput("bp_hold", 64'(holdErr), 0);
    checkOutput("bp_validGap", 64'(gapErr), 0);
    checkOutput("bp_zeroWhenIdle", 64'(zeroErr), 0);
    checkOutput("bp_doneCnt", 64'(doneCnt[0]), 1);

    $display("[TB] overflow");
    doReset();
    applyStimulus(260, 4'b0000, 0);
    runSnap(0, 0, 0, 0);
    checkStream(0, "ovf_D", 260, 0, 0, 0, 0, 8'h00);
    checkStream(1, "ovf_wrap", 4, 0, 0, 0, 0, 8'h01);
    checkStream(2, "ovf_sat", 8'hFF, 0, 0, 0, 0, 8'h01);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    runSnap(0, 0, 0, 0);
    checkStream(1, "clr_wrap", 0, 0, 0, 0, 0, 8'h00);
    checkStream(2, "clr_sat", 0, 0, 0, 0, 0, 8'h00);

    $display("[TB] snap with clear");
    applyStimulus(5, 4'b1111, 5);
    runSnap(1, 0, 0, 0);
    checkStream(0, "snapClr_D", 5, 5, 5, 5, 5, 8'h00);
    applyStimulus(7, 4'b0010, 2);
    runSnap(0, 0, 0, 0);
    checkStream(0, "afterClr_D", 7, 0, 2, 0, 0, 8'h00);

    $display("[TB] snap request during stream");
    runSnap(0, 0, 1, 0);
    checkOutput("extraReq_doneCnt", 64'(doneCnt[0]), 1);
    checkOutput("extraReq_bytes", 64'(nGot[0]), 22);

    $display("[TB] reset mid-stream");
    runSnap(0, 0, 0, 5);
    checkOutput("abort_noDone", 64'(doneCnt[0]), 0);
    runSnap(0, 0, 0, 0);
    checkStream(0, "postAbort_D", 0, 0, 0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
